// File: rtl/mem_stage_hazard_if.sv
// mem_stage_hazard_if: EX/MEM inputs, hazard controls and MEM/WB outputs of the MEM stage.
// master = producer side (EX stage / hazard unit), slave = the MEM stage itself.
// Inputs to MEM : PC_EXMEM, read_Address_EXMEM, write_Data_EXMEM, rd_EXMEM, EX/MEM controls,
//                 stall_MEM, flush_MEM
// Outputs of MEM: PCSrc, branch_target, MEM/WB registers, memData_Out_MEM,
//                 misalign_err (only when MISALIGN_CHECK_EN is defined)
interface mem_stage_hazard_if;
    logic [31:0] PC_EXMEM;
    logic [31:0] read_Address_EXMEM;
    logic [31:0] write_Data_EXMEM;
    logic [4:0]  rd_EXMEM;
    logic        branch_EXMEM;
    logic        zero_EXMEM;
    logic        memRead_EXMEM;
    logic        memWrite_EXMEM;
    logic        mem2reg_EXMEM;
    logic        RegWrite_EXMEM;
    logic        stall_MEM;
    logic        flush_MEM;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic [31:0] read_Data_MEMWB;
    logic [31:0] alu_result_MEMWB;
    logic [4:0]  rd_MEMWB;
    logic        mem2reg_MEMWB;
    logic        RegWrite_MEMWB;
    logic [31:0] memData_Out_MEM;
`ifdef MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    modport master (
        output PC_EXMEM, read_Address_EXMEM, write_Data_EXMEM, rd_EXMEM,
               branch_EXMEM, zero_EXMEM, memRead_EXMEM, memWrite_EXMEM,
               mem2reg_EXMEM, RegWrite_EXMEM, stall_MEM, flush_MEM,
        input  PCSrc, branch_target, read_Data_MEMWB, alu_result_MEMWB, rd_MEMWB,
               mem2reg_MEMWB, RegWrite_MEMWB, memData_Out_MEM
`ifdef MISALIGN_CHECK_EN
        , input misalign_err
`endif
    );

    modport slave (
        input  PC_EXMEM, read_Address_EXMEM, write_Data_EXMEM, rd_EXMEM,
               branch_EXMEM, zero_EXMEM, memRead_EXMEM, memWrite_EXMEM,
               mem2reg_EXMEM, RegWrite_EXMEM, stall_MEM, flush_MEM,
        output PCSrc, branch_target, read_Data_MEMWB, alu_result_MEMWB, rd_MEMWB,
               mem2reg_MEMWB, RegWrite_MEMWB, memData_Out_MEM
`ifdef MISALIGN_CHECK_EN
        , output misalign_err
`endif
    );
endinterface

// File: rtl/mem_stage_hazard.sv
// mem_stage_hazard: RISC-V MEM stage -- data memory, branch resolve, MEM/WB register, writeback mux.
// Ports: clk, rst (async active-high), bus (mem_stage_hazard_if.slave, see interface file).
// Optional MISALIGN_CHECK_EN: adds sticky misalign_err; misaligned loads read 0, misaligned stores dropped.
module mem_stage_hazard #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input logic               clk,
    input logic               rst,
    mem_stage_hazard_if.slave bus
);
    logic [31:0] mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic misaligned;
    logic mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] read_data_d, read_data_q;
    logic [31:0] alu_result_d, alu_result_q;
    logic [4:0]  rd_d, rd_q;
    logic        mem2reg_d, mem2reg_q;
    logic        reg_write_d, reg_write_q;

    assign idx = bus.read_Address_EXMEM[ADDR_W+1:2];
`ifdef MISALIGN_CHECK_EN
    logic misalign_err_d, misalign_err_q;
    assign misaligned = (bus.memRead_EXMEM || bus.memWrite_EXMEM) && (bus.read_Address_EXMEM[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        mem_rdata    = (bus.memRead_EXMEM && !misaligned) ? mem[idx] : 32'h0;
        mem_we       = bus.memWrite_EXMEM && !misaligned && !bus.stall_MEM && !bus.flush_MEM && !rst;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        rd_d         = rd_q;
        mem2reg_d    = mem2reg_q;
        reg_write_d  = reg_write_q;
        if (bus.flush_MEM) begin
            read_data_d  = '0;
            alu_result_d = '0;
            rd_d         = '0;
            mem2reg_d    = 1'b0;
            reg_write_d  = 1'b0;
        end else if (!bus.stall_MEM) begin
            read_data_d  = mem_rdata;
            alu_result_d = bus.read_Address_EXMEM;
            rd_d         = bus.rd_EXMEM;
            mem2reg_d    = bus.mem2reg_EXMEM;
            reg_write_d  = bus.RegWrite_EXMEM;
        end
    end

    // Memory is not reset; rst is folded into mem_we so a store at a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= bus.write_Data_EXMEM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q  <= '0;
            alu_result_q <= '0;
            rd_q         <= '0;
            mem2reg_q    <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            rd_q         <= rd_d;
            mem2reg_q    <= mem2reg_d;
            reg_write_q  <= reg_write_d;
        end
    end

`ifdef MISALIGN_CHECK_EN
    assign misalign_err_d = misalign_err_q || (misaligned && !bus.stall_MEM && !bus.flush_MEM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_err_q <= 1'b0;
        else     misalign_err_q <= misalign_err_d;
    end

    assign bus.misalign_err = misalign_err_q;
`endif

    // Branch outputs are raw; the hazard unit qualifies them with stall/flush.
    assign bus.PCSrc            = bus.branch_EXMEM & bus.zero_EXMEM;
    assign bus.branch_target    = bus.PC_EXMEM;
    assign bus.read_Data_MEMWB  = read_data_q;
    assign bus.alu_result_MEMWB = alu_result_q;
    assign bus.rd_MEMWB         = rd_q;
    assign bus.mem2reg_MEMWB    = mem2reg_q;
    assign bus.RegWrite_MEMWB   = reg_write_q;
    assign bus.memData_Out_MEM  = mem2reg_q ? read_data_q : alu_result_q;
endmodule

// File: tb/tb_mem_stage_hazard.sv
// tb_mem_stage_hazard: table-driven scoreboard bench for mem_stage_hazard.
module tb_mem_stage_hazard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    mem_stage_hazard_if bus();

    mem_stage_hazard #(.DEPTH(256), .ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr, wdata;
        logic [4:0]  rd;
        logic        mr, mw, m2r, rw, st, fl;
        logic [31:0] e_rdata, e_alu;
        logic [4:0]  e_rd;
        logic        e_m2r, e_rw;
    } vec_t;

    typedef struct {
        logic [31:0] rdata, alu;
        logic [4:0]  rd;
        logic        m2r, rw;
    } exp_t;

    vec_t vt[14];
    exp_t q[$];

    function automatic vec_t mk(logic [31:0] addr, logic [31:0] wdata, logic [4:0] rd,
                                logic mr, logic mw, logic m2r, logic rw, logic st, logic fl,
                                logic [31:0] e_rdata, logic [31:0] e_alu, logic [4:0] e_rd,
                                logic e_m2r, logic e_rw);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.rd = rd; v.mr = mr; v.mw = mw; v.m2r = m2r;
        v.rw = rw; v.st = st; v.fl = fl; v.e_rdata = e_rdata; v.e_alu = e_alu;
        v.e_rd = e_rd; v.e_m2r = e_m2r; v.e_rw = e_rw;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [31:0] addr, logic [31:0] wdata, logic [4:0] rd, logic mr,
                         logic mw, logic m2r, logic rw, logic st, logic fl);
        bus.read_Address_EXMEM = addr;
        bus.write_Data_EXMEM   = wdata;
        bus.rd_EXMEM           = rd;
        bus.memRead_EXMEM      = mr;
        bus.memWrite_EXMEM     = mw;
        bus.mem2reg_EXMEM      = m2r;
        bus.RegWrite_EXMEM     = rw;
        bus.stall_MEM          = st;
        bus.flush_MEM          = fl;
    endtask

    task automatic check_outputs(string tag, exp_t e);
        check({tag, ".rdata"}, bus.read_Data_MEMWB, e.rdata);
        check({tag, ".alu"}, bus.alu_result_MEMWB, e.alu);
        check({tag, ".rd"}, 32'(bus.rd_MEMWB), 32'(e.rd));
        check({tag, ".m2r"}, 32'(bus.mem2reg_MEMWB), 32'(e.m2r));
        check({tag, ".rw"}, 32'(bus.RegWrite_MEMWB), 32'(e.rw));
        check({tag, ".wb"}, bus.memData_Out_MEM, e.m2r ? e.rdata : e.alu);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 expected less");
        $fatal(1);
    end

    initial begin
        exp_t z;
        exp_t e;
        z = '{rdata: 32'h0, alu: 32'h0, rd: 5'd0, m2r: 1'b0, rw: 1'b0};
        bus.PC_EXMEM = 32'h0;
        bus.branch_EXMEM = 1'b0;
        bus.zero_EXMEM = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0, 0);

        //            addr          wdata         rd  mr mw m2r rw st fl  e_rdata       e_alu         e_rd m2r rw
        vt[0]  = mk(32'h10,       32'hDEADBEEF, 0,  0, 1, 0,  0, 0, 0, 32'h0,        32'h10,       0,   0,  0);
        vt[1]  = mk(32'h10,       32'h0,        5,  1, 0, 1,  1, 0, 0, 32'hDEADBEEF, 32'h10,       5,   1,  1);
        vt[2]  = mk(32'h400,      32'h1234,     0,  0, 1, 0,  0, 0, 0, 32'h0,        32'h400,      0,   0,  0);
        vt[3]  = mk(32'h0,        32'h0,        6,  1, 0, 1,  1, 0, 0, 32'h1234,     32'h0,        6,   1,  1);
        vt[4]  = mk(32'h20,       32'hA,        0,  0, 1, 0,  0, 0, 0, 32'h0,        32'h20,       0,   0,  0);
        vt[5]  = mk(32'h20,       32'hB,        7,  1, 1, 1,  1, 0, 0, 32'hA,        32'h20,       7,   1,  1);
        vt[6]  = mk(32'h20,       32'h0,        8,  1, 0, 1,  1, 0, 0, 32'hB,        32'h20,       8,   1,  1);
        vt[7]  = mk(32'h30,       32'h77,       0,  0, 1, 0,  0, 0, 0, 32'h0,        32'h30,       0,   0,  0);
        vt[8]  = mk(32'h30,       32'h99,       9,  0, 1, 0,  1, 1, 0, 32'h0,        32'h30,       0,   0,  0);
        vt[9]  = mk(32'h30,       32'h0,        10, 1, 0, 1,  1, 0, 0, 32'h77,       32'h30,       10,  1,  1);
        vt[10] = mk(32'h44,       32'h0,        11, 1, 0, 1,  1, 1, 1, 32'h0,        32'h0,        0,   0,  0);
        vt[11] = mk(32'h55,       32'h0,        12, 0, 0, 0,  1, 0, 0, 32'h0,        32'h55,       12,  0,  1);
        vt[12] = mk(32'h30,       32'hEE,       14, 0, 1, 0,  1, 0, 1, 32'h0,        32'h0,        0,   0,  0);
        vt[13] = mk(32'h30,       32'h0,        13, 1, 0, 1,  1, 0, 0, 32'h77,       32'h30,       13,  1,  1);

        @(posedge clk); #1;
        check_outputs("reset", z);
        rst = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].addr, vt[i].wdata, vt[i].rd, vt[i].mr, vt[i].mw, vt[i].m2r, vt[i].rw, vt[i].st, vt[i].fl);
            q.push_back('{rdata: vt[i].e_rdata, alu: vt[i].e_alu, rd: vt[i].e_rd, m2r: vt[i].e_m2r, rw: vt[i].e_rw});
            @(posedge clk); #1;
            if (q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard: queue empty, expected an entry");
            end else begin
                e = q.pop_front();
                check_outputs($sformatf("vec%0d", i), e);
            end
        end

        drive(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0);
        bus.PC_EXMEM = 32'h80; bus.branch_EXMEM = 1'b1; bus.zero_EXMEM = 1'b1;
        #1;
        check("pcsrc_taken", 32'(bus.PCSrc), 32'd1);
        check("branch_target", bus.branch_target, 32'h80);
        bus.zero_EXMEM = 1'b0;
        #1;
        check("pcsrc_not_taken", 32'(bus.PCSrc), 32'd0);
        bus.branch_EXMEM = 1'b0;

        @(posedge clk); #1;
        drive(32'h10, 32'h0, 5'd5, 1, 0, 1, 1, 0, 0);
        @(posedge clk); #1;
        check("pre_rst.rw", 32'(bus.RegWrite_MEMWB), 32'd1);
        check("pre_rst.rdata", bus.read_Data_MEMWB, 32'hDEADBEEF);
        drive(32'h10, 32'h5555, 5'd5, 0, 1, 0, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        check_outputs("async_rst", z);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(32'h10, 32'h0, 5'd5, 1, 0, 1, 1, 0, 0);
        @(posedge clk); #1;
        check("rst_store_dropped", bus.read_Data_MEMWB, 32'hDEADBEEF);
        check("rst_resume.rd", 32'(bus.rd_MEMWB), 32'd5);

`ifdef MISALIGN_CHECK_EN
        check("misalign_init", 32'(bus.misalign_err), 32'd0);
        drive(32'h13, 32'h0, 5'd3, 1, 0, 1, 1, 0, 0);
        @(posedge clk); #1;
        check("misalign_set", 32'(bus.misalign_err), 32'd1);
        check("misalign_rdata", bus.read_Data_MEMWB, 32'h0);
        drive(32'h55, 32'h0, 5'd4, 0, 0, 0, 1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("misalign_sticky", 32'(bus.misalign_err), 32'd1);
        rst = 1'b1;
        #1;
        check("misalign_clear", 32'(bus.misalign_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
